pl_debug_led_ctrl_mc: RTL and testbench

//  AXI4-Lite register-mapped debug LED driver with NUM_LEDS independent channels.

---
 rtl/pl_debug_led_ctrl_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_pl_debug_led_ctrl_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_debug_led_ctrl_mc.sv
// rtl/pl_debug_led_ctrl_mc.sv - AXI4-Lite debug LED driver; optional heartbeat via PL_DEBUG_LED_HEARTBEAT_EN
`timescale 1ns/1ps
module pl_debug_led_ctrl_mc #(
    parameter int NUM_LEDS   = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
`ifdef PL_DEBUG_LED_HEARTBEAT_EN
    output logic                  heartbeat_o,
`endif
    output logic [NUM_LEDS-1:0]   led_o
);

    localparam int          WI        = ADDR_WIDTH - 2;
    localparam logic [31:0] CTRL_MASK = 32'hFFFF_0001;
    localparam logic [31:0] CH_MASK   = 32'hFFFF_FF07;
`ifdef PL_DEBUG_LED_HEARTBEAT_EN
    localparam logic        HB_PRESENT = 1'b1;
`else
    localparam logic        HB_PRESENT = 1'b0;
`endif
    localparam logic [31:0] ID_VALUE  = {8'h02, 15'd0, HB_PRESENT, 8'(NUM_LEDS)};

    // Byte-lane merge; unimplemented bits are forced to zero so they read back 0.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb, input logic [31:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r & mask;
    endfunction

    logic                  aw_held, w_held;
    logic [WI-1:0]         aw_widx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            w_strb;
    logic [31:0]           ctrl_q;
    logic [31:0]           ch_q [NUM_LEDS];
    logic [15:0]           pre_cnt;
    logic [7:0]            pwm_cnt;
    logic [15:0]           blink_cnt [NUM_LEDS];
    logic [15:0]           hp_m1 [NUM_LEDS];
    logic [NUM_LEDS-1:0]   phase, raw, inv, wr_ch;
    logic                  wr_fire, wr_ctrl, wr_ok, rd_ok, tick;
    logic [31:0]           ctrl_wr_val, rd_val;
    int                    aw_idx, ar_idx;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Address decode for the held write and the incoming read, plus the read mux.
    always_comb begin
        wr_fire     = aw_held & w_held & ~S_AXI_BVALID;
        ctrl_wr_val = merge(ctrl_q, w_data, w_strb, CTRL_MASK);
        aw_idx      = int'(aw_widx);
        ar_idx      = int'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
        wr_ok       = (aw_idx == 0) || (aw_idx == 1);
        wr_ctrl     = wr_fire && (aw_idx == 0);
        rd_val      = 32'd0;
        rd_ok       = 1'b0;
        if (ar_idx == 0) begin
            rd_val = ctrl_q;
            rd_ok  = 1'b1;
        end else if (ar_idx == 1) begin
            rd_val = ID_VALUE;
            rd_ok  = 1'b1;
        end
        for (int n = 0; n < NUM_LEDS; n++) begin
            wr_ch[n] = 1'b0;
            if (aw_idx == n + 4) begin
                wr_ch[n] = wr_fire;
                wr_ok    = 1'b1;
            end
            if (ar_idx == n + 4) begin
                rd_val = ch_q[n];
                rd_ok  = 1'b1;
            end
        end
    end

    // AXI handshakes: registered one-cycle READY pulses, one outstanding write and read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RDATA   <= '0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_widx       <= '0;
            w_data        <= '0;
            w_strb        <= 4'd0;
        end else begin
            S_AXI_AWREADY <= ~S_AXI_AWREADY & S_AXI_AWVALID & ~aw_held & ~S_AXI_BVALID;
            S_AXI_WREADY  <= ~S_AXI_WREADY & S_AXI_WVALID & ~w_held & ~S_AXI_BVALID;
            S_AXI_ARREADY <= ~S_AXI_ARREADY & S_AXI_ARVALID & ~S_AXI_RVALID;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held <= 1'b1;
                aw_widx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_val;
                S_AXI_RRESP  <= rd_ok ? 2'b00 : 2'b10;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Register file update on a completed write; ID and unmapped writes are dropped.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl_q <= 32'd0;
            for (int n = 0; n < NUM_LEDS; n++) ch_q[n] <= 32'd0;
        end else begin
            if (wr_ctrl) ctrl_q <= ctrl_wr_val;
            for (int n = 0; n < NUM_LEDS; n++) begin
                if (wr_ch[n]) ch_q[n] <= merge(ch_q[n], w_data, w_strb, CH_MASK);
            end
        end
    end

    // Per-channel raw waveform selection and blink terminal count.
    always_comb begin
        tick = (pre_cnt == 16'd0);
        for (int n = 0; n < NUM_LEDS; n++) begin
            hp_m1[n] = (ch_q[n][31:16] == 16'd0) ? 16'd0 : ch_q[n][31:16] - 16'd1;
            inv[n]   = ch_q[n][2];
            case (ch_q[n][1:0])
                2'd0:    raw[n] = 1'b0;
                2'd1:    raw[n] = 1'b1;
                2'd2:    raw[n] = phase[n];
                default: raw[n] = (pwm_cnt < ch_q[n][15:8]);
            endcase
        end
    end

    // Time base: prescaler, shared PWM counter and per-channel blink counters.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pre_cnt <= 16'd0;
            pwm_cnt <= 8'd0;
            phase   <= '0;
            for (int n = 0; n < NUM_LEDS; n++) blink_cnt[n] <= 16'd0;
        end else begin
            if (wr_ctrl)   pre_cnt <= ctrl_wr_val[31:16];
            else if (tick) pre_cnt <= ctrl_q[31:16];
            else           pre_cnt <= pre_cnt - 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
            for (int n = 0; n < NUM_LEDS; n++) begin
                if (wr_ch[n]) begin
                    blink_cnt[n] <= 16'd0;
                    phase[n]     <= 1'b0;
                end else if (tick) begin
                    if (blink_cnt[n] >= hp_m1[n]) begin
                        blink_cnt[n] <= 16'd0;
                        phase[n]     <= ~phase[n];
                    end else begin
                        blink_cnt[n] <= blink_cnt[n] + 16'd1;
                    end
                end
            end
        end
    end

    // Registered LED drive, gated by the global enable.
    always_ff @(posedge ACLK) begin
        if (ARESET) led_o <= '0;
        else        led_o <= ctrl_q[0] ? (raw ^ inv) : '0;
    end

`ifdef PL_DEBUG_LED_HEARTBEAT_EN
    logic [23:0] hb_cnt;

    // Free-running heartbeat, toggles once per 2^24 cycles.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            hb_cnt      <= 24'd0;
            heartbeat_o <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + 24'd1;
            if (&hb_cnt) heartbeat_o <= ~heartbeat_o;
        end
    end
`endif

endmodule

// File: tb/tb_pl_debug_led_ctrl_mc.sv
// tb/tb_pl_debug_led_ctrl_mc.sv - self-checking bench for pl_debug_led_ctrl_mc
`timescale 1ns/1ps
module tb_pl_debug_led_ctrl_mc;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [6:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [6:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [7:0]  led_o;
`ifdef PL_DEBUG_LED_HEARTBEAT_EN
    logic        heartbeat_o;
    localparam logic [31:0] ID_EXP = 32'h0200_0108;
`else
    localparam logic [31:0] ID_EXP = 32'h0200_0008;
`endif

    int tests = 0;
    int fails = 0;
    logic [1:0]  bexp_q[$];
    logic [33:0] rexp_q[$];

    pl_debug_led_ctrl_mc #(.NUM_LEDS(8), .ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
`ifdef PL_DEBUG_LED_HEARTBEAT_EN
        .heartbeat_o(heartbeat_o),
`endif
        .led_o(led_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [6:0] addr);
        int n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 50);
        check("awready_seen", S_AXI_AWREADY, 1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!S_AXI_WREADY && n < 50);
        check("wready_seen", S_AXI_WREADY, 1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        S_AXI_BREADY = 1'b1;
        do begin @(negedge ACLK); n++; end while (!S_AXI_BVALID && n < 100);
        check("bvalid_seen", S_AXI_BVALID, 1);
        check("bresp", S_AXI_BRESP, bexp_q.pop_front());
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW then W, 2 = W then AW
    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int order, input logic [1:0] resp);
        bexp_q.push_back(resp);
        if (order == 1) begin
            send_aw(addr);
            send_w(data, strb);
        end else if (order == 2) begin
            send_w(data, strb);
            send_aw(addr);
        end else begin
            fork
                send_aw(addr);
                send_w(data, strb);
            join
        end
        wait_b();
    endtask

    task automatic axi_read(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        logic [33:0] e;
        rexp_q.push_back({resp, data});
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 50);
        check("arready_seen", S_AXI_ARREADY, 1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_RVALID && n < 100);
        check("rvalid_seen", S_AXI_RVALID, 1);
        e = rexp_q.pop_front();
        check("rdata", {2'b00, S_AXI_RDATA}, {2'b00, e[31:0]});
        check("rresp", S_AXI_RRESP, e[33:32]);
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic count_high(input int idx, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge ACLK);
            if (led_o[idx]) cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, per, cnt, acc, drop;
        logic prev;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        // T1 reset state and reset register values
        @(negedge ACLK);
        check("rst_led", led_o, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_awready", S_AXI_AWREADY, 0);
        axi_read(7'h00, 32'h0, 2'b00);
        axi_read(7'h04, ID_EXP, 2'b00);
        axi_read(7'h10, 32'h0, 2'b00);

        // T2 static ON, invert, byte strobes, ID write ignored
        axi_write(7'h10, 32'h0000_0001, 4'hF, 0, 2'b00);
        axi_write(7'h00, 32'h0000_0001, 4'hF, 1, 2'b00);
        repeat (2) @(negedge ACLK);
        check("t2_on", led_o[0], 1);
        axi_write(7'h10, 32'hFFFF_0005, 4'h1, 2, 2'b00);
        repeat (2) @(negedge ACLK);
        check("t2_invert", led_o[0], 0);
        axi_read(7'h10, 32'h0000_0005, 2'b00);
        axi_write(7'h00, 32'h1234_5601, 4'hC, 0, 2'b00);
        axi_read(7'h00, 32'h1234_0001, 2'b00);
        axi_write(7'h04, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
        axi_read(7'h04, ID_EXP, 2'b00);

        // T3 blink: tick every 4 cycles, half period 2 ticks
        axi_write(7'h00, 32'h0003_0001, 4'hF, 0, 2'b00);
        axi_write(7'h14, 32'h0002_0002, 4'hF, 0, 2'b00);
        n = 0;
        @(negedge ACLK); prev = led_o[1];
        do begin @(negedge ACLK); n++; if (!prev && led_o[1]) break; prev = led_o[1]; end while (n < 100);
        check("t3_rise_found", led_o[1], 1);
        hi = 1; per = 0; prev = 1'b1;
        do begin
            @(negedge ACLK); per++;
            if (!prev && led_o[1]) break;
            if (led_o[1]) hi++;
            prev = led_o[1];
        end while (per < 100);
        check("t3_period", per, 16);
        check("t3_high", hi, 8);

        // T4 PWM with tick every cycle: duty 64, 0 and 255
        axi_write(7'h00, 32'h0000_0001, 4'hF, 0, 2'b00);
        axi_write(7'h18, 32'h0000_4003, 4'hF, 0, 2'b00);
        count_high(2, 256, cnt);
        check("t4_duty64", cnt, 64);
        axi_write(7'h18, 32'h0000_0003, 4'hF, 0, 2'b00);
        count_high(2, 256, cnt);
        check("t4_duty0", cnt, 0);
        axi_write(7'h18, 32'h0000_FF03, 4'hF, 0, 2'b00);
        count_high(2, 256, cnt);
        check("t4_duty255", cnt, 255);

        // global enable gates everything, including inverted OFF channels
        axi_write(7'h1C, 32'h0000_0004, 4'hF, 0, 2'b00);
        repeat (2) @(negedge ACLK);
        check("en_invert_off", led_o[3], 1);
        axi_write(7'h00, 32'h0000_0000, 4'hF, 0, 2'b00);
        repeat (2) @(negedge ACLK);
        check("en_off_all", led_o, 0);

        // T5 unmapped addresses, handshake ordering, BREADY backpressure
        axi_write(7'h0C, 32'hDEAD_BEEF, 4'hF, 1, 2'b10);
        axi_read(7'h0C, 32'h0, 2'b10);
        axi_write(7'h30, 32'hDEAD_BEEF, 4'hF, 2, 2'b10);
        axi_read(7'h30, 32'h0, 2'b10);
        axi_read(7'h08, 32'h0, 2'b10);
        bexp_q.push_back(2'b00);
        fork
            send_aw(7'h20);
            send_w(32'h0000_0001, 4'hF);
        join
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_BVALID && n < 100);
        check("t5_bvalid_seen", S_AXI_BVALID, 1);
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 7'h24; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1; S_AXI_WVALID = 1'b1;
        acc = 0; drop = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY || S_AXI_WREADY) acc++;
            if (!S_AXI_BVALID) drop++;
        end
        check("t5_bvalid_held", drop, 0);
        check("t5_no_accept", acc, 0);
        check("t5_bresp", S_AXI_BRESP, bexp_q.pop_front());
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("t5_bvalid_clear", S_AXI_BVALID, 0);
        axi_read(7'h24, 32'h0, 2'b00);

        // simultaneous read and write of one register: read sees the old value
        fork
            axi_write(7'h20, 32'h00FF_0001, 4'hF, 0, 2'b00);
            axi_read(7'h20, 32'h0000_0001, 2'b00);
        join
        axi_read(7'h20, 32'h00FF_0001, 2'b00);

        // T6 reset mid-blink with a read response pending
        axi_write(7'h00, 32'h0003_0001, 4'hF, 0, 2'b00);
        repeat (20) @(negedge ACLK);
        S_AXI_ARADDR = 7'h14; S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 50);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_RVALID && n < 50);
        check("t6_rvalid_pending", S_AXI_RVALID, 1);
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("t6_rvalid_drop", S_AXI_RVALID, 0);
        check("t6_led_off", led_o, 0);
        check("t6_rdata_clear", S_AXI_RDATA, 0);
        axi_read(7'h00, 32'h0, 2'b00);
        axi_read(7'h14, 32'h0, 2'b00);
        count_high(1, 40, cnt);
        check("t6_led_stays_off", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
